score_collector: RTL and testbench



---
 rtl/score_collector.sv | 89 ++++++++
 tb/tb_score_collector.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_collector.sv
// Collects a serial valid/ready stream of class scores into a parallel bank.
// Optional feature macro: SCORE_COLLECTOR_CLAMP_EN (store negative scores as zero).
module score_collector #(
    parameter int unsigned DataWidth  = 16,
    parameter int unsigned NumClasses = 10
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [DataWidth-1:0]            in_data_i,
    input  logic                            in_last_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [NumClasses*DataWidth-1:0] out_scores_o,
    output logic                            err_o
);

    localparam int unsigned CntW = (NumClasses > 1) ? $clog2(NumClasses) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NumClasses - 1);

    typedef enum logic [0:0] {StCollect, StFull} state_e;

    state_e                                    state_q, state_d;
    logic [CntW-1:0]                           cnt_q, cnt_d;
    logic [NumClasses-1:0][DataWidth-1:0]      slot_q, slot_d;
    logic                                      err_q, err_d;
    logic                                      accept;
    logic [DataWidth-1:0]                      wdata;

    assign in_ready_o   = (state_q == StCollect) && rst_ni;
    assign accept       = in_valid_i && in_ready_o;
    assign out_valid_o  = (state_q == StFull);
    assign out_scores_o = slot_q;
    assign err_o        = err_q;

`ifdef SCORE_COLLECTOR_CLAMP_EN
    // Negative scores become zero so the unsigned arg-max downstream stays correct.
    assign wdata = in_data_i[DataWidth-1] ? '0 : in_data_i;
`else
    assign wdata = in_data_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        err_d   = 1'b0;
        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    slot_d[cnt_q] = wdata;
                    if (cnt_q == CntLast) begin
                        // The beat count is authoritative; a missing last is flagged only.
                        cnt_d   = '0;
                        state_d = StFull;
                        err_d   = !in_last_i;
                    end else if (in_last_i) begin
                        cnt_d = '0;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StFull: begin
                if (out_ready_i) begin
                    state_d = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StCollect;
            cnt_q   <= '0;
            slot_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_score_collector.sv
// Scoreboard bench for score_collector: frames are queued when driven, compared when presented.
module tb_score_collector;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 10;
    localparam int unsigned OW = DW * NC;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_last;
    logic [DW-1:0] in_data;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          err;
    logic [OW-1:0] out_scores;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_err_cnt = 0;
    int err_seen = 0;
    int frames_pushed = 0;
    int frames_seen = 0;
    int or_mode = 0;
    logic err_prev = 1'b0;
    logic [OW-1:0] exp_q[$];
    logic [DW-1:0] fd[NC];

    always #5 clk = ~clk;

    score_collector #(
        .DataWidth (DW),
        .NumClasses(NC)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_scores_o(out_scores),
        .err_o       (err)
    );

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] stored(input logic [DW-1:0] x);
`ifdef SCORE_COLLECTOR_CLAMP_EN
        return x[DW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    always @(posedge clk) cyc++;

    // Downstream acceptance pattern: 0 = hold off, 1 = always ready, else random.
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", OW'(out_valid), OW'(0));
            end else begin
                chk("frame", out_scores, exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    frames_seen++;
                end
            end
        end
        if (err_prev && err) chk("err_width", OW'(err), OW'(0));
        if (err) err_seen++;
        err_prev = err;
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic exp_e);
        int n = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) begin
            chk("accept_timeout", OW'(acc), OW'(1));
        end else begin
            chk("err_after_beat", OW'(err), OW'(exp_e));
            if (exp_e) exp_err_cnt++;
        end
    endtask

    // Sends fd[0..nbeats-1]; last_at is the beat index carrying in_last (-1 for none).
    task automatic send_frame(input int nbeats, input int last_at, input int gap_max);
        logic [OW-1:0] f;
        logic last;
        logic exp_e;
        if (nbeats == NC) begin
            for (int k = 0; k < NC; k++) f[k*DW +: DW] = stored(fd[k]);
            exp_q.push_back(f);
            frames_pushed++;
        end
        for (int i = 0; i < nbeats; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            last  = (i == last_at);
            exp_e = (last && i < NC - 1) || (i == NC - 1 && !last);
            send_beat(fd[i], last, exp_e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", OW'(exp_q.size()), OW'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, OW'(in_ready), OW'(0));
        chk({tag, "_out_valid"}, OW'(out_valid), OW'(0));
        chk({tag, "_err"}, OW'(err), OW'(0));
        chk({tag, "_scores"}, out_scores, OW'(0));
    endtask

    initial begin
        int start;
        int n;
        logic [DW-1:0] slot_exp;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", OW'(in_ready), OW'(1));
        @(posedge clk);
        #1;

        // Zero-wait frame, downstream holding off.
        or_mode = 0;
        for (int i = 0; i < NC; i++) fd[i] = DW'(16'h0010 + i);
        start = cyc;
        send_frame(NC, NC - 1, 0);
        chk("stream_cycles", OW'(cyc - start), OW'(NC));
        chk("ov_latency", OW'(out_valid), OW'(1));
        chk("in_ready_full", OW'(in_ready), OW'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_hold", OW'(in_ready), OW'(0));
        chk("ov_hold", OW'(out_valid), OW'(1));
        chk("slot9", OW'(out_scores[9*DW +: DW]), OW'(16'h0019));
        or_mode = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_ready && out_valid) && n < 20);
        chk("no_bypass", OW'(in_ready), OW'(0));
        @(posedge clk);
        #1;
        chk("ready_release", OW'(in_ready), OW'(1));
        chk("ov_drop", OW'(out_valid), OW'(0));

        // Early last on beat 4, then a good frame.
        for (int i = 0; i < NC; i++) fd[i] = DW'(16'h0100 + i);
        send_frame(4, 3, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("no_frame_after_early", OW'(out_valid), OW'(0));
        for (int i = 0; i < NC; i++) fd[i] = DW'(16'h0200 + i);
        send_frame(NC, NC - 1, 1);
        drain();

        // Missing last: flagged but emitted.
        for (int i = 0; i < NC; i++) fd[i] = DW'(16'h0300 + i);
        send_frame(NC, -1, 0);
        drain();

        // Negative score in slot 2.
        or_mode = 0;
        for (int i = 0; i < NC; i++) fd[i] = DW'(16'h0040 + i);
        fd[2] = 16'hFFF0;
`ifdef SCORE_COLLECTOR_CLAMP_EN
        slot_exp = 16'h0000;
`else
        slot_exp = 16'hFFF0;
`endif
        send_frame(NC, NC - 1, 0);
        chk("neg_slot", OW'(out_scores[2*DW +: DW]), OW'(slot_exp));
        or_mode = 1;
        drain();

        // Random gaps and random downstream stalls over three frames.
        or_mode = 2;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NC; i++) fd[i] = DW'($urandom);
            send_frame(NC, NC - 1, 3);
        end
        drain();

        // Reset after beat 6 loses the partial frame.
        or_mode = 1;
        for (int i = 0; i < NC; i++) fd[i] = DW'(16'h0500 + i);
        send_frame(6, -1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        for (int i = 0; i < NC; i++) fd[i] = DW'(16'h0600 + i);
        send_frame(NC, NC - 1, 0);
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk("err_count", OW'(err_seen), OW'(exp_err_cnt));
        chk("frame_count", OW'(frames_seen), OW'(frames_pushed));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
